// File: rtl/jts16_fd1094_keyld_if.sv
// Bus bundle between the FD1094 key loader, the SDRAM key region and the decoder key RAM.
// The master modport is the loader; the slave modport is its surroundings.
interface jts16_fd1094_keyld_if #(
    parameter int KEYAW = 13,
    parameter int ROMAW = 22
);
    logic             start;
    logic [ROMAW-1:0] base;
    logic [ROMAW-1:0] rom_addr;
    logic             rom_cs;
    logic [15:0]      rom_data;
    logic             rom_ok;
    logic [KEYAW-1:0] prog_addr;
    logic [7:0]       prog_data;
    logic             fd1094_we;
    logic             busy;
    logic             dec_en;
    logic [7:0]       sum;

    modport master (
        input  start, base, rom_data, rom_ok,
        output rom_addr, rom_cs, prog_addr, prog_data, fd1094_we, busy, dec_en, sum
    );

    modport slave (
        output start, base, rom_data, rom_ok,
        input  rom_addr, rom_cs, prog_addr, prog_data, fd1094_we, busy, dec_en, sum
    );
endinterface

// File: rtl/jts16_fd1094_keyld.sv
// Copies the FD1094 key from SDRAM into the decoder key RAM, one 16-bit word per fetch,
// low byte first, and enables decryption only once every byte has been written.
module jts16_fd1094_keyld #(
    parameter int KEYAW = 13,
    parameter int ROMAW = 22
) (
    input  logic                     clk,
    input  logic                     rst,
    jts16_fd1094_keyld_if.master     bus
);
    localparam int WCW = KEYAW - 1;

    typedef enum logic [2:0] {IDLE, REQ, WR_LO, WR_HI, DONE} state_e;

    state_e           state_q, state_d;
    logic [WCW-1:0]   cnt_q, cnt_d;
    logic [ROMAW-1:0] base_q, base_d;
    logic [15:0]      word_q, word_d;
    logic             got_q, got_d;
    logic [KEYAW-1:0] prog_addr_q, prog_addr_d;
    logic [7:0]       sum_q, sum_d;
    logic             dec_en_q, dec_en_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            word_q      <= '0;
            got_q       <= 1'b0;
            prog_addr_q <= '0;
            sum_q       <= '0;
            dec_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            word_q      <= word_d;
            got_q       <= got_d;
            prog_addr_q <= prog_addr_d;
            sum_q       <= sum_d;
            dec_en_q    <= dec_en_d;
        end
    end

    // NOTE: every next-state value gets its hold default first, so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        word_d      = word_q;
        got_d       = got_q;
        prog_addr_d = prog_addr_q;
        sum_d       = sum_q;
        dec_en_d    = dec_en_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = REQ;
                    cnt_d       = '0;
                    base_d      = bus.base;
                    prog_addr_d = '0;
                    sum_d       = '0;
                    dec_en_d    = 1'b0;
                    got_d       = 1'b0;
                end
            end
            REQ: begin
                // got_q marks the one-cycle gap after rom_ok in which rom_cs is already low
                if (got_q) begin
                    got_d   = 1'b0;
                    state_d = WR_LO;
                end else if (bus.rom_ok) begin
                    word_d = bus.rom_data;
                    got_d  = 1'b1;
                end
            end
            WR_LO: begin
                prog_addr_d = prog_addr_q + KEYAW'(1);
                sum_d       = sum_q + word_q[7:0];
                state_d     = WR_HI;
            end
            WR_HI: begin
                prog_addr_d = prog_addr_q + KEYAW'(1);
                sum_d       = sum_q + word_q[15:8];
                cnt_d       = cnt_q + WCW'(1);
                if (&cnt_q) begin
                    state_d  = DONE;
                    dec_en_d = 1'b1;
                end else begin
                    state_d = REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.rom_cs    = (state_q == REQ) && !got_q;
    assign bus.rom_addr  = base_q + ROMAW'(cnt_q);
    assign bus.fd1094_we = (state_q == WR_LO) || (state_q == WR_HI);
    assign bus.prog_data = (state_q == WR_HI) ? word_q[15:8] : word_q[7:0];
    assign bus.prog_addr = prog_addr_q;
    assign bus.busy      = (state_q == REQ) || (state_q == WR_LO) || (state_q == WR_HI);
    assign bus.dec_en    = dec_en_q;
    assign bus.sum       = sum_q;
endmodule

// File: doc/jts16_fd1094_keyld.md
JTS16_FD1094_KEYLD -- requirements
Module: jts16_fd1094_keyld

Interface
REQ-001 Parameter: KEYAW, default 13, key byte address width (key size 2^KEYAW bytes).
REQ-002 Parameter: ROMAW, default 22, word address width of the SDRAM key region.
REQ-003 Port: clk  in  1  single system clock; all logic on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: start  in  1  one-cycle pulse requesting a key load.
REQ-006 Port: base  in  ROMAW  SDRAM word address of key byte 0.
REQ-007 Port: rom_addr  out  ROMAW  SDRAM word address being fetched.
REQ-008 Port: rom_cs  out  1  SDRAM read request, held until rom_ok.
REQ-009 Port: rom_data  in  16  SDRAM read data, valid when rom_ok=1.
REQ-010 Port: rom_ok  in  1  SDRAM data-valid acknowledge.
REQ-011 Port: prog_addr  out  KEYAW  key RAM byte address to the FD1094 decoder.
REQ-012 Port: prog_data  out  8  key byte to the FD1094 decoder.
REQ-013 Port: fd1094_we  out  1  key RAM write strobe, one byte per asserted cycle.
REQ-014 Port: busy  out  1  high while a load is in progress.
REQ-015 Port: dec_en  out  1  high only after a complete, uninterrupted load; gates decryption.
REQ-016 Port: sum  out  8  modulo-256 sum of all bytes written in the last load.

Function
REQ-017 FSM states: IDLE, REQ, WR_LO, WR_HI, DONE.
REQ-018 IDLE: start=1 -> word counter cleared, prog_addr=0, sum=0, dec_en=0, busy=1, go to REQ next cycle.
REQ-019 REQ: rom_cs=1, rom_addr=base+word counter; rom_cs stays high and rom_addr stable until a cycle with rom_ok=1.
REQ-020 REQ with rom_ok=1: rom_data latched, rom_cs=0 on the next cycle, go to WR_LO.
REQ-021 WR_LO: fd1094_we=1, prog_data=latched[7:0], prog_addr even; sum+=byte; prog_addr+1; go to WR_HI.
REQ-022 WR_HI: fd1094_we=1, prog_data=latched[15:8], prog_addr odd; sum+=byte; prog_addr+1; word counter+1.
REQ-023 WR_HI exit: last word (counter was 2^(KEYAW-1)-1) -> DONE; else -> REQ.
REQ-024 prog_addr wraps to 0 after the final byte; it never exceeds 2^KEYAW-1 during a write.
REQ-025 DONE: busy=0, dec_en=1, sum held; go to IDLE-with-key (dec_en kept) next cycle.
REQ-026 start while busy=1: ignored; no restart, no counter change.
REQ-027 start in IDLE after a completed load: dec_en drops to 0 on the cycle after start; full reload.
REQ-028 Latency: each word costs (cycles until rom_ok) + 3 cycles; rom_ok asserted in the first REQ cycle gives 4 cycles/word.
REQ-029 rom_ok outside REQ: ignored.
REQ-030 fd1094_we: never asserted outside WR_LO/WR_HI; exactly 2^KEYAW write strobes per load.
REQ-031 base: sampled at start; later base changes do not affect an ongoing load.

Reset
REQ-032 rst=1: next edge -> IDLE, rom_cs=0, fd1094_we=0, busy=0, dec_en=0, prog_addr=0, prog_data=0, sum=0, rom_addr=0.
REQ-033 rst mid-load: load aborted, dec_en stays 0; a new start is required; no partial DONE.
REQ-034 rst and start in the same cycle: rst wins; FSM stays in IDLE.

Verification
REQ-035 KEYAW=3, base=0x100, words 0x0201,0x0403,0x0605,0x0807, rom_ok 1 cycle after each request -> bytes 01..08 written at prog_addr 0..7, 8 strobes, sum=0x24, dec_en=1.
REQ-036 rom_ok delayed 10 cycles on word 2 -> rom_cs held with rom_addr=0x102 for the whole wait; no fd1094_we during the wait.
REQ-037 start pulsed again at write 3 -> ignored; byte sequence and sum unchanged.
REQ-038 rst pulsed after byte 5 -> busy=0, dec_en=0, sum=0; a new start reloads from prog_addr 0 and completes.
REQ-039 Default KEYAW=13, all words 0xFFFF -> 8192 strobes, prog_addr ends wrapped at 0, sum=0x00, dec_en=1.
REQ-040 Completed load followed by a new start -> dec_en low from the next cycle until the second DONE.
